// File: rtl/mbist_pkg.sv
// Shared types for the MBIST fault-injection memory: fault encodings, FSM
// states and the fault-table entry layout.
package mbist_pkg;

    localparam int unsigned FT_ADDR_MAX = 16;
    localparam int unsigned FT_BIT_MAX  = 8;

    typedef enum logic [1:0] {
        FT_NONE = 2'b00,
        FT_SA0  = 2'b01,
        FT_SA1  = 2'b10,
        FT_TFUP = 2'b11
    } fault_type_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Fields are sized for the widest supported memory; narrower ports zero-extend.
    typedef struct packed {
        logic [FT_ADDR_MAX-1:0] addr;
        logic [FT_BIT_MAX-1:0]  bit_idx;
        fault_type_e            ftype;
    } fault_entry_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fault_inject_memory_if.sv
// Memory access, fault-table config and hit-counter signals of the
// fault-injection memory, bundled for the MBIST/MBISR path.
interface fault_inject_memory_if
    import mbist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_FAULTS = 4,
    parameter int unsigned CNT_WIDTH  = 8
);
    localparam int unsigned IDX_W = idx_width(NUM_FAULTS);
    localparam int unsigned BIT_W = idx_width(DATA_WIDTH);

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  busy;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [IDX_W-1:0]      cfg_idx;
    logic [ADDR_WIDTH-1:0] cfg_addr;
    logic [BIT_W-1:0]      cfg_bit;
    logic [1:0]            cfg_type;
    logic                  cnt_clr;
    logic [CNT_WIDTH-1:0]  hit_count;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        output cfg_valid, cfg_idx, cfg_addr, cfg_bit, cfg_type, cnt_clr,
        input  mem_rdata, busy, cfg_ready, hit_count
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  cfg_valid, cfg_idx, cfg_addr, cfg_bit, cfg_type, cnt_clr,
        output mem_rdata, busy, cfg_ready, hit_count
    );

endinterface

// File: rtl/fault_inject_memory_fault_table.sv
// Run-time programmable fault table: registered entries plus combinational
// per-address force-0 / force-1 / transition-block masks.
module fault_table
    import mbist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_FAULTS = 4,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned BIT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [BIT_W-1:0]      cfg_bit,
    input  logic [1:0]            cfg_type,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic [DATA_WIDTH-1:0] force0,
    output logic [DATA_WIDTH-1:0] force1,
    output logic [DATA_WIDTH-1:0] tf_mask
);

    fault_entry_t entries [NUM_FAULTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_FAULTS; i++) begin
                entries[i] <= '{addr: '0, bit_idx: '0, ftype: FT_NONE};
            end
        end else if (cfg_we && (32'(cfg_idx) < NUM_FAULTS)) begin
            entries[cfg_idx] <= '{addr:    FT_ADDR_MAX'(cfg_addr),
                                  bit_idx: FT_BIT_MAX'(cfg_bit),
                                  ftype:   fault_type_e'(cfg_type)};
        end
    end

    // Ascending scan so a higher-index stuck-at entry overrides a lower one on the same bit.
    always_comb begin
        force0  = '0;
        force1  = '0;
        tf_mask = '0;
        for (int unsigned i = 0; i < NUM_FAULTS; i++) begin
            if (entries[i].addr == FT_ADDR_MAX'(lookup_addr)) begin
                for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
                    if (entries[i].bit_idx == FT_BIT_MAX'(b)) begin
                        case (entries[i].ftype)
                            FT_SA0: begin
                                force0[b] = 1'b1;
                                force1[b] = 1'b0;
                            end
                            FT_SA1: begin
                                force1[b] = 1'b1;
                                force0[b] = 1'b0;
                            end
                            FT_TFUP: tf_mask[b] = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fault_inject_memory.sv
// Memory responder with run-time stuck-at / transition fault injection,
// post-reset clear sweep and a saturating corrupted-access counter.
module fault_inject_memory
    import mbist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_SIZE   = 32,
    parameter int unsigned NUM_FAULTS = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input logic                  clk,
    input logic                  rst,
    fault_inject_memory_if.slave bus
);

    localparam int unsigned IDX_W = idx_width(NUM_FAULTS);
    localparam int unsigned BIT_W = idx_width(DATA_WIDTH);

    state_e                state;
    logic [ADDR_WIDTH-1:0] sweep;
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  busy_q;
    logic                  cfg_ready_q;
    logic [CNT_WIDTH-1:0]  hit_q;

    logic                  in_range;
    logic                  access;
    logic                  wr_acc;
    logic [DATA_WIDTH-1:0] force0, force1, tf_mask;
    logic [DATA_WIDTH-1:0] stored;
    logic [DATA_WIDTH-1:0] read_word;
    logic [DATA_WIDTH-1:0] blocked;
    logic [DATA_WIDTH-1:0] write_word;
    logic                  hit_event;

    assign in_range = (32'(bus.mem_addr) < MEM_SIZE);
    assign access   = (state == READY) && bus.mem_en;
    assign wr_acc   = access && bus.mem_we && in_range;

    fault_table #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_FAULTS (NUM_FAULTS),
        .IDX_W      (IDX_W),
        .BIT_W      (BIT_W)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (bus.cfg_valid && cfg_ready_q),
        .cfg_idx     (bus.cfg_idx),
        .cfg_addr    (bus.cfg_addr),
        .cfg_bit     (bus.cfg_bit),
        .cfg_type    (bus.cfg_type),
        .lookup_addr (bus.mem_addr),
        .force0      (force0),
        .force1      (force1),
        .tf_mask     (tf_mask)
    );

    // Out-of-range addresses read as zero and see no fault masks.
    always_comb begin
        stored = '0;
        if (in_range) begin
            stored = mem[bus.mem_addr];
        end
        read_word  = in_range ? ((stored & ~force0) | force1) : '0;
        blocked    = in_range ? (tf_mask & ~stored & bus.mem_wdata) : '0;
        write_word = bus.mem_wdata & ~blocked;
        hit_event  = bus.mem_we ? (|blocked) : (read_word != stored);
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[sweep] <= '0;
        end else if (wr_acc) begin
            mem[bus.mem_addr] <= write_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= CLEAR;
            sweep       <= '0;
            busy_q      <= 1'b1;
            cfg_ready_q <= 1'b0;
            rdata_q     <= '0;
            hit_q       <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (sweep == ADDR_WIDTH'(MEM_SIZE - 1)) begin
                        state       <= READY;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end else begin
                        sweep <= sweep + ADDR_WIDTH'(1);
                    end
                end
                READY: begin
                    if (access && !bus.mem_we) begin
                        rdata_q <= read_word;
                    end
                end
                default: state <= CLEAR;
            endcase

            if (bus.cnt_clr) begin
                hit_q <= '0;
            end else if (access && hit_event && (hit_q != '1)) begin
                hit_q <= hit_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.cfg_ready = cfg_ready_q;
    assign bus.hit_count = hit_q;

endmodule

// File: tb/tb_fault_inject_memory.sv
// Self-checking bench for fault_inject_memory: directed vector table,
// saturation and reset-sweep sequences, then randomized traffic vs. a model.
module tb_fault_inject_memory;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;
    localparam int unsigned MS = 32;
    localparam int unsigned NF = 4;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fault_inject_memory_if #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_FAULTS (NF),
        .CNT_WIDTH  (CW)
    ) bus ();

    fault_inject_memory #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_SIZE   (MS),
        .NUM_FAULTS (NF),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic we, input logic [4:0] addr,
                         input logic [7:0] wd, input logic cv, input logic [1:0] ci,
                         input logic [4:0] ca, input logic [2:0] cb, input logic [1:0] ct,
                         input logic clr);
        bus.mem_en    = en;
        bus.mem_we    = we;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        bus.cfg_valid = cv;
        bus.cfg_idx   = ci;
        bus.cfg_addr  = ca;
        bus.cfg_bit   = cb;
        bus.cfg_type  = ct;
        bus.cnt_clr   = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 2'd0, 5'd0, 3'd0, 2'd0, 1'b0);
    endtask

    task automatic wait_sweep(input string name);
        int n = 0;
        while (bus.busy && n < 100) begin
            step();
            n++;
        end
        check(name, 32'(n), 32'd32);
    endtask

    typedef struct {
        logic       en, we;
        logic [4:0] addr;
        logic [7:0] wd;
        logic       cv;
        logic [1:0] ci;
        logic [4:0] ca;
        logic [2:0] cb;
        logic [1:0] ct;
        logic       clr;
        logic [7:0] rd;
        logic [7:0] hit;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic we, input logic [4:0] addr,
                                input logic [7:0] wd, input logic cv, input logic [1:0] ci,
                                input logic [4:0] ca, input logic [2:0] cb, input logic [1:0] ct,
                                input logic clr, input logic [7:0] rd, input logic [7:0] hit);
        vec_t v;
        v.en = en; v.we = we; v.addr = addr; v.wd = wd;
        v.cv = cv; v.ci = ci; v.ca = ca; v.cb = cb; v.ct = ct;
        v.clr = clr; v.rd = rd; v.hit = hit;
        return v;
    endfunction

    // Reference model: memory words, fault list and counter in plain arrays.
    logic [7:0] m_mem   [MS];
    logic [4:0] m_faddr [NF];
    logic [2:0] m_fbit  [NF];
    logic [1:0] m_ftype [NF];
    logic [7:0] m_rd;
    logic [7:0] m_hit;

    task automatic model_reset();
        for (int i = 0; i < int'(MS); i++) m_mem[i] = 8'h00;
        for (int i = 0; i < int'(NF); i++) begin
            m_faddr[i] = 5'd0;
            m_fbit[i]  = 3'd0;
            m_ftype[i] = 2'b00;
        end
        m_rd  = 8'h00;
        m_hit = 8'h00;
    endtask

    task automatic model_step(input logic en, input logic we, input logic [4:0] addr,
                              input logic [7:0] wd, input logic cv, input logic [1:0] ci,
                              input logic [4:0] ca, input logic [2:0] cb, input logic [1:0] ct,
                              input logic clr);
        logic       corrupted = 1'b0;
        logic [7:0] word;
        if (en) begin
            word = m_mem[addr];
            if (we) begin
                for (int b = 0; b < 8; b++) begin
                    logic rises = !word[b] && wd[b];
                    logic held  = 1'b0;
                    for (int i = 0; i < int'(NF); i++)
                        if (m_ftype[i] == 2'b11 && m_faddr[i] == addr && int'(m_fbit[i]) == b)
                            held = 1'b1;
                    if (rises && held) corrupted = 1'b1;
                    word[b] = (rises && held) ? 1'b0 : wd[b];
                end
                m_mem[addr] = word;
            end else begin
                for (int b = 0; b < 8; b++) begin
                    for (int i = int'(NF) - 1; i >= 0; i--) begin
                        if ((m_ftype[i] == 2'b01 || m_ftype[i] == 2'b10) &&
                            m_faddr[i] == addr && int'(m_fbit[i]) == b) begin
                            word[b] = (m_ftype[i] == 2'b10);
                            break;
                        end
                    end
                end
                corrupted = (word != m_mem[addr]);
                m_rd = word;
            end
        end
        if (clr) m_hit = 8'h00;
        else if (corrupted && m_hit != 8'hFF) m_hit = m_hit + 8'h01;
        if (cv) begin
            m_faddr[ci] = ca;
            m_fbit[ci]  = cb;
            m_ftype[ci] = ct;
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) step();
        check("rst_rdata", 32'(bus.mem_rdata), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h1);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'h0);
        check("rst_hit", 32'(bus.hit_count), 32'h0);
        rst = 1'b0;
        wait_sweep("busy_cycles");
        check("cfg_ready_up", 32'(bus.cfg_ready), 32'h1);

        //            en we addr   wd     cv ci ca     cb ct clr  rd     hit
        vecs.push_back(mk(1, 0, 5'h07, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'h00, 8'd0));
        vecs.push_back(mk(1, 1, 5'h03, 8'hA5, 0, 0, 5'h00, 0, 0, 0, 8'h00, 8'd0));
        vecs.push_back(mk(1, 0, 5'h03, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'hA5, 8'd0));
        vecs.push_back(mk(0, 1, 5'h03, 8'hFF, 0, 0, 5'h00, 0, 0, 0, 8'hA5, 8'd0));
        vecs.push_back(mk(1, 0, 5'h03, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'hA5, 8'd0));
        vecs.push_back(mk(0, 0, 5'h00, 8'h00, 1, 0, 5'h04, 0, 2, 0, 8'hA5, 8'd0));
        vecs.push_back(mk(1, 1, 5'h04, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'hA5, 8'd0));
        vecs.push_back(mk(1, 0, 5'h04, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'h01, 8'd1));
        vecs.push_back(mk(1, 1, 5'h04, 8'h01, 0, 0, 5'h00, 0, 0, 0, 8'h01, 8'd1));
        vecs.push_back(mk(1, 0, 5'h04, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'h01, 8'd1));
        vecs.push_back(mk(0, 0, 5'h00, 8'h00, 1, 1, 5'h10, 7, 3, 0, 8'h01, 8'd1));
        vecs.push_back(mk(1, 1, 5'h10, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'h01, 8'd1));
        vecs.push_back(mk(1, 1, 5'h10, 8'hFF, 0, 0, 5'h00, 0, 0, 0, 8'h01, 8'd2));
        vecs.push_back(mk(1, 0, 5'h10, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'h7F, 8'd2));
        vecs.push_back(mk(1, 1, 5'h10, 8'h80, 0, 0, 5'h00, 0, 0, 0, 8'h7F, 8'd3));
        vecs.push_back(mk(1, 0, 5'h10, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'h00, 8'd3));
        vecs.push_back(mk(0, 0, 5'h00, 8'h00, 1, 0, 5'h02, 3, 1, 0, 8'h00, 8'd3));
        vecs.push_back(mk(0, 0, 5'h00, 8'h00, 1, 3, 5'h02, 3, 2, 0, 8'h00, 8'd3));
        vecs.push_back(mk(1, 1, 5'h02, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'h00, 8'd3));
        vecs.push_back(mk(1, 0, 5'h02, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'h08, 8'd4));
        vecs.push_back(mk(1, 1, 5'h05, 8'h40, 0, 0, 5'h00, 0, 0, 0, 8'h08, 8'd4));
        vecs.push_back(mk(1, 0, 5'h05, 8'h00, 1, 2, 5'h05, 1, 2, 0, 8'h40, 8'd4));
        vecs.push_back(mk(1, 0, 5'h05, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'h42, 8'd5));
        vecs.push_back(mk(1, 1, 5'h1F, 8'h3C, 0, 0, 5'h00, 0, 0, 0, 8'h42, 8'd5));
        vecs.push_back(mk(1, 0, 5'h1F, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'h3C, 8'd5));
        vecs.push_back(mk(1, 0, 5'h04, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'h01, 8'd5));
        vecs.push_back(mk(0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 0, 0, 1, 8'h01, 8'd0));
        vecs.push_back(mk(1, 0, 5'h02, 8'h00, 0, 0, 5'h00, 0, 0, 1, 8'h08, 8'd0));
        vecs.push_back(mk(0, 0, 5'h00, 8'h00, 1, 1, 5'h10, 7, 0, 0, 8'h08, 8'd0));
        vecs.push_back(mk(1, 1, 5'h10, 8'hFF, 0, 0, 5'h00, 0, 0, 0, 8'h08, 8'd0));
        vecs.push_back(mk(1, 0, 5'h10, 8'h00, 0, 0, 5'h00, 0, 0, 0, 8'hFF, 8'd0));

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].cv,
                  vecs[i].ci, vecs[i].ca, vecs[i].cb, vecs[i].ct, vecs[i].clr);
            step();
            check($sformatf("vec%0d_rdata", i), 32'(bus.mem_rdata), 32'(vecs[i].rd));
            check($sformatf("vec%0d_hit", i), 32'(bus.hit_count), 32'(vecs[i].hit));
        end

        // Saturation: address 0x02 reads back 0x08 from a stored 0x00.
        drive(1, 0, 5'h02, 8'h00, 0, 0, 5'h00, 0, 0, 0);
        repeat (254) step();
        check("sat_254", 32'(bus.hit_count), 32'hFE);
        step();
        check("sat_255", 32'(bus.hit_count), 32'hFF);
        repeat (45) step();
        check("sat_300", 32'(bus.hit_count), 32'hFF);
        drive(1, 0, 5'h02, 8'h00, 0, 0, 5'h00, 0, 0, 1);
        step();
        check("sat_clr", 32'(bus.hit_count), 32'h00);
        idle();

        // Reset in the middle of the sweep restarts it from word 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        check("mid_busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        step();
        check("mid_rst_rdata", 32'(bus.mem_rdata), 32'h0);
        rst = 1'b0;
        wait_sweep("mid_busy_cycles");
        drive(1, 0, 5'h03, 8'h00, 0, 0, 5'h00, 0, 0, 0);
        step();
        check("cleared_0x03", 32'(bus.mem_rdata), 32'h0);
        drive(1, 0, 5'h02, 8'h00, 0, 0, 5'h00, 0, 0, 0);
        step();
        check("cleared_faults", 32'(bus.hit_count), 32'h0);

        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic       en, we, cv, clr;
            logic [4:0] addr, ca;
            logic [7:0] wd;
            logic [1:0] ci, ct;
            logic [2:0] cb;
            en   = ($urandom_range(0, 3) != 0);
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            wd   = 8'($urandom);
            cv   = ($urandom_range(0, 7) == 0);
            ci   = 2'($urandom_range(0, 3));
            ca   = 5'($urandom_range(0, 3));
            cb   = 3'($urandom_range(0, 7));
            ct   = 2'($urandom_range(0, 3));
            clr  = ($urandom_range(0, 49) == 0);
            model_step(en, we, addr, wd, cv, ci, ca, cb, ct, clr);
            drive(en, we, addr, wd, cv, ci, ca, cb, ct, clr);
            step();
            check($sformatf("rnd%0d_rdata", n), 32'(bus.mem_rdata), 32'(m_rd));
            check($sformatf("rnd%0d_hit", n), 32'(bus.hit_count), 32'(m_hit));
        end
        idle();
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fault_inject_memory.md
Name: fault_inject_memory

Overview:
Synthesizable memory responder for the MBIST/MBISR demo path. It sits on the far side of the mem_en/mem_we/mem_addr/mem_wdata/mem_rdata interface that the MBIST controller drives through the MBISR remapper, and it is a drop-in alternative to the plain memory array. A small, run-time programmable fault table injects stuck-at and transition faults, so the March C- detection and spare-row repair flow can be exercised on silicon. It counts the accesses that were corrupted by injected faults.

Parameters:
ADDR_WIDTH, 5, address width
DATA_WIDTH, 8, data word width
MEM_SIZE, 32, number of words; addresses >= MEM_SIZE are out of range
NUM_FAULTS, 4, fault table entries
CNT_WIDTH, 8, width of the hit counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_en  in  1  access strobe
mem_we  in  1  1 = write, 0 = read; qualified by mem_en
mem_addr  in  ADDR_WIDTH  access address
mem_wdata  in  DATA_WIDTH  write data
mem_rdata  out  DATA_WIDTH  registered read data
busy  out  1  high during the post-reset clear sweep
cfg_valid  in  1  fault-table write request
cfg_ready  out  1  fault table can accept a write
cfg_idx  in  clog2(NUM_FAULTS)  table entry to write
cfg_addr  in  ADDR_WIDTH  faulty word address
cfg_bit  in  clog2(DATA_WIDTH)  faulty bit index
cfg_type  in  2  00 none, 01 SA0, 10 SA1, 11 TF-up (cell cannot rise 0->1)
cnt_clr  in  1  synchronous clear of hit_count
hit_count  out  CNT_WIDTH  saturating count of corrupted accesses

Behaviour:
- Interface is one clock and one reset. Reset (rst) is asynchronous and active-high. Reset values: mem_rdata=0, busy=1, cfg_ready=0, hit_count=0, all table entries type=00.
- FSM states:
  - CLEAR, entered on reset. A sweep pointer writes 0 to words 0..MEM_SIZE-1, one word per cycle. busy=1 and cfg_ready=0. mem_en is ignored and mem_rdata stays 0. After the last word, go to READY; busy falls exactly MEM_SIZE cycles after reset release.
  - READY: busy=0, cfg_ready=1. Stays here until the next reset. Asserting rst mid-sweep or mid-operation restarts CLEAR from word 0.
- Config handshake: an entry is written on a cycle where cfg_valid && cfg_ready. The new entry takes effect from the next cycle. An access in the same cycle uses the old table contents.
- Read (mem_en=1, mem_we=0):
  - mem_rdata updates on the next rising edge, so latency is 1.
  - The data is the stored word with each SA0/SA1 entry whose address matches forcing its bit to 0/1.
  - Several entries on the same bit: the highest index wins.
  - mem_rdata holds its value on every cycle without a read.
- Write (mem_en=1, mem_we=1):
  - The stored word is updated. For each matching TF-up entry where the stored bit is 0 and the wdata bit is 1, the stored bit stays 0. Falling 1->0 transitions are unaffected.
  - SA faults do not alter stored data; they act only on reads.
  - mem_rdata is unchanged on a write.
- Out of range (addr >= MEM_SIZE): writes are ignored, reads return 0, and no faults apply.
- hit_count: +1 on a read whose output differs from the stored word, or on a write in which at least one TF-up entry blocked a bit. At most +1 per access. Saturates at all-ones. cnt_clr zeroes it on the next edge and takes priority over a same-cycle increment.
- mem_en=0 means no access, no state change, and no count.

Decomposition:
- Package mbist_pkg holds:
  - fault type encodings FT_NONE/FT_SA0/FT_SA1/FT_TFUP
  - FSM state encodings CLEAR/READY
  - a fault-entry struct typedef {addr, bit, type}
- One sub-module, fault_table, holds the NUM_FAULTS registered entries and the config write port. It produces, for a given address, combinational force-0, force-1 and tf-block masks. fault_inject_memory owns the array, FSM, read register and counter.

Test Plan:
- Reset release: busy stays high 32 cycles, then falls. Read addr 0x07 returns 0x00 on the next cycle, and cfg_ready=1.
- No faults: write 0xA5 to 0x03, then read 0x03 -> mem_rdata=0xA5 one cycle after the read strobe; hit_count=0.
- SA1 bit 0 at 0x04: write 0x00, read -> 0x01, hit_count=1. Write 0x01, read -> 0x01, hit_count unchanged.
- TF-up bit 7 at 0x10: write 0x00, then 0xFF, read -> 0x7F, hit_count=1. Write 0x80 after 0x7F is stored, read -> 0x00.
- Conflict and timing:
  - SA0 idx0 and SA1 idx3 on the same bit at 0x02: read -> bit forced to 1.
  - A cfg write in the same cycle as a read of the target address does not affect that read; the following read is affected.
- Boundaries:
  - Drive 300 corrupted reads -> hit_count saturates at 0xFF. cnt_clr together with a corrupted read -> 0x00.
  - rst asserted mid-sweep: the sweep restarts and busy stays high 32 cycles after release.
